// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a DEPTH x WIDTH asynchronous-read memory between two
// request ports, one grant per cycle, with registered per-port read responses.
module mem_port_arbiter #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32,
    parameter bit FIXED_PRIO = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_req0_valid,
    output logic             io_req0_ready,
    input  logic             io_req0_wen,
    input  logic [31:0]      io_req0_addr,
    input  logic [WIDTH-1:0] io_req0_wdata,
    output logic             io_resp0_valid,
    output logic [WIDTH-1:0] io_resp0_data,
    input  logic             io_req1_valid,
    output logic             io_req1_ready,
    input  logic             io_req1_wen,
    input  logic [31:0]      io_req1_addr,
    input  logic [WIDTH-1:0] io_req1_wdata,
    output logic             io_resp1_valid,
    output logic [WIDTH-1:0] io_resp1_data
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic             last_grant;
    logic             grant0;
    logic             grant1;
    logic             rd0;
    logic             rd1;
    logic             wen;
    logic [AW-1:0]    idx;
    logic [WIDTH-1:0] wdata;
    logic             unused_addr;

    assign unused_addr = ^{io_req0_addr[31:AW], io_req1_addr[31:AW]};

    // On contention the port not named by last_grant wins; fixed mode pins it to port 0.
    always_comb begin
        grant0 = !reset && io_req0_valid && (!io_req1_valid || FIXED_PRIO || last_grant);
        grant1 = !reset && io_req1_valid && !grant0;
        idx    = grant1 ? io_req1_addr[AW-1:0] : io_req0_addr[AW-1:0];
        wen    = grant1 ? io_req1_wen : io_req0_wen;
        wdata  = grant1 ? io_req1_wdata : io_req0_wdata;
        rd0    = grant0 && !io_req0_wen;
        rd1    = grant1 && !io_req1_wen;
    end

    assign io_req0_ready = grant0;
    assign io_req1_ready = grant1;

    always_ff @(posedge clk) begin
        if ((grant0 || grant1) && wen)
            mem[idx] <= wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_grant <= 1'b1;
        else if (grant0 || grant1)
            last_grant <= grant1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            io_resp0_valid <= 1'b0;
            io_resp1_valid <= 1'b0;
            io_resp0_data  <= '0;
            io_resp1_data  <= '0;
        end else begin
            io_resp0_valid <= rd0;
            io_resp1_valid <= rd1;
            if (rd0)
                io_resp0_data <= mem[idx];
            if (rd1)
                io_resp1_data <= mem[idx];
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: round-robin (k=0) and fixed-priority (k=1) instances driven
// independently, checked by a memory/queue reference model and a response monitor.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        v[2][2];
    logic        w[2][2];
    logic [31:0] a[2][2];
    logic [31:0] d[2][2];
    logic        rdy[2][2];
    logic        rv[2][2];
    logic [31:0] rd[2][2];

    logic [31:0] mm[2][8];
    bit          kn[2][8];
    bit          lg[2];
    logic [32:0] q[2][2][$];
    logic [31:0] last[2][2];
    bit          lk[2][2];
    int          rc[2][2];
    int          glog[2][$];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        mem_port_arbiter #(.DEPTH(8), .WIDTH(32), .FIXED_PRIO(k)) dut (
            .clk(clk), .reset(reset),
            .io_req0_valid(v[k][0]), .io_req0_ready(rdy[k][0]), .io_req0_wen(w[k][0]),
            .io_req0_addr(a[k][0]), .io_req0_wdata(d[k][0]),
            .io_resp0_valid(rv[k][0]), .io_resp0_data(rd[k][0]),
            .io_req1_valid(v[k][1]), .io_req1_ready(rdy[k][1]), .io_req1_wen(w[k][1]),
            .io_req1_addr(a[k][1]), .io_req1_wdata(d[k][1]),
            .io_resp1_valid(rv[k][1]), .io_resp1_data(rd[k][1])
        );
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic set_req(input int k, input int p, input bit wen, input logic [31:0] addr,
                           input logic [31:0] data);
        v[k][p] = 1'b1;
        w[k][p] = wen;
        a[k][p] = addr;
        d[k][p] = data;
    endtask

    // One clock cycle: predict grants, check ready, update the model, retire granted requests.
    task automatic step();
        bit g[2][2];
        int win;
        @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            g[k][0] = 0;
            g[k][1] = 0;
            win = -1;
            if (!reset) begin
                if (v[k][0] && v[k][1]) win = (k == 1) ? 0 : (lg[k] ? 0 : 1);
                else if (v[k][0]) win = 0;
                else if (v[k][1]) win = 1;
            end
            if (win >= 0) g[k][win] = 1;
            for (int p = 0; p < 2; p++)
                chk($sformatf("ready k%0d p%0d", k, p), {31'd0, rdy[k][p]}, {31'd0, g[k][p]});
            if (win >= 0) begin
                lg[k] = (win == 1);
                glog[k].push_back(win);
                if (w[k][win]) begin
                    mm[k][a[k][win] % 8] = d[k][win];
                    kn[k][a[k][win] % 8] = 1;
                end else
                    q[k][win].push_back({kn[k][a[k][win] % 8], mm[k][a[k][win] % 8]});
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 2; p++)
                if (g[k][p]) v[k][p] = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            lg[k] = 1;
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("rst resp_valid k%0d p%0d", k, p), {31'd0, rv[k][p]}, 32'd0);
                chk($sformatf("rst resp_data k%0d p%0d", k, p), rd[k][p], 32'd0);
                chk($sformatf("rst ready k%0d p%0d", k, p), {31'd0, rdy[k][p]}, 32'd0);
                q[k][p].delete();
                last[k][p] = '0;
                lk[k][p] = 1;
            end
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++)
                for (int p = 0; p < 2; p++) begin
                    logic [32:0] e;
                    chk($sformatf("resp_valid k%0d p%0d", k, p), {31'd0, rv[k][p]},
                        {31'd0, q[k][p].size() != 0});
                    if (rv[k][p]) rc[k][p]++;
                    if (q[k][p].size() != 0) begin
                        e = q[k][p].pop_front();
                        if (rv[k][p] && e[32])
                            chk($sformatf("resp_data k%0d p%0d", k, p), rd[k][p], e[31:0]);
                        last[k][p] = e[31:0];
                        lk[k][p] = e[32];
                    end else if (lk[k][p])
                        chk($sformatf("resp_hold k%0d p%0d", k, p), rd[k][p], last[k][p]);
                end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) kn[k][i] = 0;
            for (int p = 0; p < 2; p++) begin
                v[k][p] = 0; w[k][p] = 0; a[k][p] = 0; d[k][p] = 0; rc[k][p] = 0;
            end
        end
        do_reset();

        for (int k = 0; k < 2; k++) set_req(k, 0, 1, 3, 32'hDEADBEEF);
        step();
        for (int k = 0; k < 2; k++) set_req(k, 0, 0, 3, 0);
        step();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("wr_rd valid0 k%0d", k), {31'd0, rv[k][0]}, 32'd1);
            chk($sformatf("wr_rd data0 k%0d", k), rd[k][0], 32'hDEADBEEF);
            chk($sformatf("wr_rd valid1 k%0d", k), {31'd0, rv[k][1]}, 32'd0);
        end
        step();

        do_reset();
        for (int k = 0; k < 2; k++) begin
            glog[k].delete();
            rc[k][0] = 0;
            rc[k][1] = 0;
        end
        for (int c = 0; c < 6; c++) begin
            for (int k = 0; k < 2; k++) begin
                set_req(k, 0, 0, 3, 0);
                set_req(k, 1, 0, 3, 0);
            end
            step();
        end
        for (int k = 0; k < 2; k++) begin
            v[k][0] = 0;
            v[k][1] = 0;
        end
        step();
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("rr grant %0d", c), glog[0][c], c % 2);
            chk($sformatf("fixed grant %0d", c), glog[1][c], 0);
        end
        chk("rr resp count p0", rc[0][0], 3);
        chk("rr resp count p1", rc[0][1], 3);
        chk("fixed resp count p0", rc[1][0], 6);
        chk("fixed resp count p1", rc[1][1], 0);

        for (int k = 0; k < 2; k++) set_req(k, 1, 1, 32'h9, 32'h12345678);
        step();
        for (int k = 0; k < 2; k++) set_req(k, 0, 0, 1, 0);
        step();
        for (int k = 0; k < 2; k++) chk($sformatf("alias data k%0d", k), rd[k][0], 32'h12345678);

        for (int k = 0; k < 2; k++) set_req(k, 0, 1, 5, 32'hA5A5A5A5);
        step();
        for (int k = 0; k < 2; k++) set_req(k, 1, 0, 5, 0);
        step();
        for (int k = 0; k < 2; k++) chk($sformatf("xraw data k%0d", k), rd[k][1], 32'hA5A5A5A5);

        for (int k = 0; k < 2; k++) set_req(k, 0, 0, 3, 0);
        step();
        for (int k = 0; k < 2; k++) begin
            set_req(k, 0, 0, 2, 0);
            set_req(k, 1, 0, 2, 0);
        end
        do_reset();
        for (int k = 0; k < 2; k++) glog[k].delete();
        step();
        for (int k = 0; k < 2; k++) chk($sformatf("post-reset grant k%0d", k), glog[k][0], 0);

        for (int c = 0; c < 2000; c++) begin
            for (int k = 0; k < 2; k++)
                for (int p = 0; p < 2; p++)
                    if (!v[k][p] && $urandom_range(1, 0) == 1)
                        set_req(k, p, $urandom_range(1, 0) == 1, $urandom, $urandom);
            step();
        end
        for (int k = 0; k < 2; k++) begin
            v[k][0] = 0;
            v[k][1] = 0;
        end
        step();
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
